// File: rtl/if_id_pkg.sv
// if_id_pkg: shared constants and entry type for the IF/ID boundary queue.
// The canonical NOP and default datapath width live here so fetch, decode
// and the queue agree on what an empty slot looks like.
package if_id_pkg;

   // Default datapath width for PC and instruction words
   localparam int IF_ID_WIDTH = 32;

   // addi x0,x0,0 -- presented to decode whenever the queue has nothing valid
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // One queued fetch result
   typedef struct packed {
      logic [IF_ID_WIDTH-1:0] pc;
      logic [IF_ID_WIDTH-1:0] instr;
   } if_id_entry_t;

endpackage : if_id_pkg

// File: rtl/if_id_queue.sv
// if_id_queue: circular {PC, Instr} buffer between fetch and decode.
// Valid/ready on both sides; flush discards every entry in one cycle.
// Optional feature macro: IF_ID_BYPASS_EN -- when defined, an empty queue
// forwards the incoming fetch combinationally to the decode side.
module if_id_queue
   import if_id_pkg::*;
#(
   parameter int WIDTH = IF_ID_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           Instr,
   input  logic [WIDTH-1:0]           PC,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           Curr_Instr,
   output logic [WIDTH-1:0]           Curr_PC,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] pc_mem_q    [DEPTH];
   logic [WIDTH-1:0] instr_mem_q [DEPTH];

   logic bypass_s;
   logic push_s;
   logic pop_s;
   logic take_s;
   logic wr_en_s;

   // Pointer advance with explicit wrap, since DEPTH need not be a power of two
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      if (p == PW'(DEPTH-1)) begin
         r = PW'(0);
      end else begin
         r = p + PW'(1);
      end
      return r;
   endfunction

   // Handshake and head-of-queue presentation towards fetch and decode
   always_comb begin
      bypass_s = 1'b0;
`ifdef IF_ID_BYPASS_EN
      if ((count_q == CW'(0)) && in_valid && !flush && !reset) begin
         bypass_s = 1'b1;
      end else begin
         bypass_s = 1'b0;
      end
`endif
      in_ready  = (count_q != CW'(DEPTH));
      out_valid = (count_q != CW'(0)) || bypass_s;
      if (bypass_s) begin
         Curr_Instr = Instr;
         Curr_PC    = PC;
      end else if (count_q != CW'(0)) begin
         Curr_Instr = instr_mem_q[rd_ptr_q];
         Curr_PC    = pc_mem_q[rd_ptr_q];
      end else begin
         Curr_Instr = WIDTH'(NOP_INSTR);
         Curr_PC    = WIDTH'(0);
      end
      count = count_q;
   end

   // Next pointers/occupancy: reset, then flush, then push/pop
   always_comb begin
      push_s   = in_valid & in_ready;
      pop_s    = out_valid & out_ready;
      take_s   = bypass_s & out_ready;
      wr_en_s  = 1'b0;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (reset || flush) begin
         rd_ptr_d = PW'(0);
         wr_ptr_d = PW'(0);
         count_d  = CW'(0);
      end else if (take_s) begin
         // forwarded straight to decode and consumed: nothing is stored
         count_d = count_q;
      end else begin
         if (push_s) begin
            wr_en_s  = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end else begin
            wr_en_s = 1'b0;
         end
         if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= PW'(0);
         wr_ptr_q <= PW'(0);
         count_q  <= CW'(0);
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents survive flush/reset, validity comes from count
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         pc_mem_q[wr_ptr_q]    <= PC;
         instr_mem_q[wr_ptr_q] <= Instr;
      end
   end

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: table vectors, directed corner sequences and randomized
// traffic on a DEPTH=2 and a DEPTH=3 instance, each tracked by a queue model.
module tb_if_id_queue;
   import if_id_pkg::*;

`ifdef IF_ID_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] pc_i, instr_i;
   logic        ir2, ov2, ir3, ov3;
   logic [31:0] cins2, cpc2, cins3, cpc3;
   logic [1:0]  cnt2, cnt3;

   if_id_queue #(.WIDTH(32), .DEPTH(2)) dut2 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
      .Instr(instr_i), .PC(pc_i), .in_ready(ir2), .out_valid(ov2),
      .out_ready(out_ready), .Curr_Instr(cins2), .Curr_PC(cpc2), .count(cnt2));

   if_id_queue #(.WIDTH(32), .DEPTH(3)) dut3 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
      .Instr(instr_i), .PC(pc_i), .in_ready(ir3), .out_valid(ov3),
      .out_ready(out_ready), .Curr_Instr(cins3), .Curr_PC(cpc3), .count(cnt3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int tests = 0;
   int fails = 0;
   bit checking = 1'b0;
   bit rec_on = 1'b0;
   bit acc3;
   logic        s_ov2, s_ir2;
   logic [31:0] s_pc2, s_ins2, s_cnt2;
   logic [31:0] popped[$];
   if_id_entry_t q2[$];
   if_id_entry_t q3[$];

   typedef struct packed {
      logic r, f, iv, ordy;
      logic [31:0] pc, ins;
      logic chk;
      logic [1:0] e_cnt;
      logic e_ov, e_ir;
      logic [31:0] e_pc, e_ins;
   } vec_t;
   vec_t vt[16];

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // compare one instance against the model queue contents
   task automatic chk_one(input string nm, input int depth, input int sz,
                          input if_id_entry_t head, input logic ov, input logic ir,
                          input logic [31:0] cpc, input logic [31:0] cins,
                          input logic [31:0] cnt);
      logic byp;
      logic [31:0] epc, eins;
      byp = BYP && (sz == 0) && in_valid && !flush && !reset;
      if (byp) begin
         epc = pc_i; eins = instr_i;
      end else if (sz != 0) begin
         epc = head.pc; eins = head.instr;
      end else begin
         epc = 32'd0; eins = NOP;
      end
      cmp({nm, ".out_valid"}, {31'd0, ov}, {31'd0, (sz != 0) || byp});
      cmp({nm, ".in_ready"}, {31'd0, ir}, {31'd0, sz != depth});
      cmp({nm, ".Curr_PC"}, cpc, epc);
      cmp({nm, ".Curr_Instr"}, cins, eins);
      cmp({nm, ".count"}, cnt, sz);
   endtask

   task automatic step(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [31:0] p, input logic [31:0] ins);
      int sz;
      logic byp;
      if_id_entry_t h2, h3, e;
      @(negedge clk);
      reset = r; flush = f; in_valid = iv; out_ready = ordy; pc_i = p; instr_i = ins;
      #1;
      s_ov2 = ov2; s_ir2 = ir2; s_pc2 = cpc2; s_ins2 = cins2; s_cnt2 = {30'd0, cnt2};
      acc3 = iv & ir3;
      if (rec_on && ov3 && ordy) popped.push_back(cpc3);
      if (checking) begin
         h2 = (q2.size() != 0) ? q2[0] : '0;
         h3 = (q3.size() != 0) ? q3[0] : '0;
         chk_one("d2", 2, q2.size(), h2, ov2, ir2, cpc2, cins2, {30'd0, cnt2});
         chk_one("d3", 3, q3.size(), h3, ov3, ir3, cpc3, cins3, {30'd0, cnt3});
      end
      @(posedge clk);
      e.pc = p; e.instr = ins;
      // model: depth-2 queue
      if (r || f) q2.delete();
      else begin
         sz = q2.size();
         byp = BYP && (sz == 0) && iv;
         if (!(byp && ordy)) begin
            if (sz != 0 && ordy) void'(q2.pop_front());
            if (iv && sz != 2) q2.push_back(e);
         end
      end
      // model: depth-3 queue
      if (r || f) q3.delete();
      else begin
         sz = q3.size();
         byp = BYP && (sz == 0) && iv;
         if (!(byp && ordy)) begin
            if (sz != 0 && ordy) void'(q3.pop_front());
            if (iv && sz != 3) q3.push_back(e);
         end
      end
   endtask

   initial begin
      logic [31:0] nextpc;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      pc_i = 32'd0; instr_i = 32'd0;

      //        r     f     iv    or    pc        ins           chk  cnt   ov    ir    e_pc      e_ins
      vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 2'd0, 1'b0, 1'b1, 32'h00, NOP};
      vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 2'd0, 1'b0, 1'b1, 32'h00, NOP};
      vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 32'h00500093, 1'b1, 2'd0, 1'b0, 1'b1, 32'h00, NOP};
      vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 2'd1, 1'b1, 1'b1, 32'h00, 32'h00500093};
      vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 32'h0,        1'b1, 2'd1, 1'b1, 1'b1, 32'h00, 32'h00500093};
      vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 2'd0, 1'b0, 1'b1, 32'h00, NOP};
      vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h04, 32'h000000A4, 1'b1, 2'd0, 1'b0, 1'b1, 32'h00, NOP};
      vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h08, 32'h000000A8, 1'b1, 2'd1, 1'b1, 1'b1, 32'h04, 32'h000000A4};
      vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0C, 32'h000000AC, 1'b1, 2'd2, 1'b1, 1'b0, 32'h04, 32'h000000A4};
      vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0C, 32'h000000AC, 1'b1, 2'd2, 1'b1, 1'b0, 32'h04, 32'h000000A4};
      vt[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0C, 32'h000000AC, 1'b1, 2'd1, 1'b1, 1'b1, 32'h08, 32'h000000A8};
      vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h000000B0, 1'b1, 2'd2, 1'b1, 1'b0, 32'h08, 32'h000000A8};
      vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 2'd0, 1'b0, 1'b1, 32'h00, NOP};
      vt[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h14, 32'h000000B4, 1'b1, 2'd0, 1'b0, 1'b1, 32'h00, NOP};
      vt[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h18, 32'h000000B8, 1'b1, 2'd1, 1'b1, 1'b1, 32'h14, 32'h000000B4};
      vt[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 2'd0, 1'b0, 1'b1, 32'h00, NOP};

      // bring both instances out of reset before the model is trusted
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      checking = 1'b1;

`ifndef IF_ID_BYPASS_EN
      // table vectors on the DEPTH=2 instance
      for (int i = 0; i < 16; i++) begin
         step(vt[i].r, vt[i].f, vt[i].iv, vt[i].ordy, vt[i].pc, vt[i].ins);
         if (vt[i].chk) begin
            cmp($sformatf("vec%0d.count", i), s_cnt2, {30'd0, vt[i].e_cnt});
            cmp($sformatf("vec%0d.out_valid", i), {31'd0, s_ov2}, {31'd0, vt[i].e_ov});
            cmp($sformatf("vec%0d.in_ready", i), {31'd0, s_ir2}, {31'd0, vt[i].e_ir});
            cmp($sformatf("vec%0d.Curr_PC", i), s_pc2, vt[i].e_pc);
            cmp($sformatf("vec%0d.Curr_Instr", i), s_ins2, vt[i].e_ins);
         end
      end
`else
      // zero-latency forward on an empty queue, consumed without storing
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0000_1111);
      cmp("byp.out_valid", {31'd0, s_ov2}, 32'd1);
      cmp("byp.Curr_PC", s_pc2, 32'h40);
      cmp("byp.Curr_Instr", s_ins2, 32'h0000_1111);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      cmp("byp.count_after", s_cnt2, 32'd0);
      cmp("byp.out_valid_after", {31'd0, s_ov2}, 32'd0);
`endif

      // DEPTH=3 stream across pointer wrap with decode toggling ready
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      nextpc = 32'd0;
      rec_on = 1'b1;
      for (int c = 0; c < 100 && popped.size() < 10; c++) begin
         step(1'b0, 1'b0, nextpc <= 32'h24, c[0], nextpc, nextpc ^ 32'h1234_0000);
         if (acc3 && nextpc <= 32'h24) nextpc = nextpc + 32'd4;
      end
      rec_on = 1'b0;
      cmp("stream.popped_count", popped.size(), 32'd10);
      for (int k = 0; k < 10; k++) begin
         if (k < popped.size()) cmp($sformatf("stream.pc%0d", k), popped[k], 32'(k * 4));
      end

      // randomized traffic with occasional flush and reset
      for (int n = 0; n < 1500; n++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
              $urandom, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_if_id_queue

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID boundary buffer, successor to the single-entry IF/ID register. Holds up to DEPTH fetched {PC, instruction} pairs in a circular queue with valid/ready handshakes on both sides, so fetch keeps running while decode stalls. Flush empties it in one cycle on a taken branch or jump. Sits between instruction memory/PC logic and the decode stage.

## Interface
Parameters:
- WIDTH, 32, width of PC and instruction words
- DEPTH, 2, queue entries; legal range 2..16, not necessarily a power of two

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; empties the queue
- flush  input  1  synchronous discard of all entries (branch/jump redirect)
- in_valid  input  1  fetch presents a valid Instr/PC this cycle
- Instr  input  WIDTH  fetched instruction
- PC  input  WIDTH  PC of Instr
- in_ready  output  1  queue accepts a push this cycle
- out_valid  output  1  Curr_Instr/Curr_PC hold a valid entry
- out_ready  input  1  decode consumes the head this cycle (deasserted = stall)
- Curr_Instr  output  WIDTH  head instruction; NOP_INSTR when empty
- Curr_PC  output  WIDTH  head PC; 0 when empty
- count  output  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH entries of {PC, Instr}. Read pointer rd_ptr and write pointer wr_ptr, each width $clog2(DEPTH). Occupancy counter is count.
- Pointers wrap explicitly: value DEPTH-1 increments to 0. There is no power-of-two masking.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (count != DEPTH). A full queue does not accept a push even when a pop happens in the same cycle.
- out_valid = (count != 0).
- Head output: Curr_Instr/Curr_PC = entry[rd_ptr] when out_valid. Otherwise Curr_Instr = NOP_INSTR and Curr_PC = 0.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
- Priority, highest first:
  1. reset
  2. flush
  3. push/pop
- flush or reset in a cycle: rd_ptr = wr_ptr = 0 and count = 0. Any simultaneous push or pop is discarded.
- Entry contents are not cleared on flush or reset. Validity comes only from count.
- Data that fetch presents while in_ready=0 is not captured. Fetch holds PC and retries.

## Timing
- Reset values, visible the cycle after reset is sampled high:
  - count=0, out_valid=0, in_ready=1
  - Curr_Instr=NOP_INSTR, Curr_PC=0
- Latency without bypass: an entry pushed at edge N appears on Curr_* with out_valid=1 in cycle N+1.
- Throughput is one push and one pop per cycle while 0 < count < DEPTH.
- Stall: with out_ready=0, Curr_*/out_valid stay stable. The queue fills to DEPTH, then in_ready drops the next cycle.
- Full boundary: when count=DEPTH, in_ready=0. A pop that cycle sets count=DEPTH-1 and in_ready=1 the next cycle.
- Empty boundary: when count=0, a pop is impossible because out_valid=0. out_ready is ignored.
- Flush with outputs: out_valid=0 and in_ready=1 in the cycle after flush.
- Reset asserted mid-operation behaves identically to flush.

## Configuration
- IF_ID_BYPASS_EN defined:
  - When count=0, in_valid=1 and flush=0, out_valid=1 and Curr_Instr/Curr_PC show Instr/PC combinationally in the same cycle.
  - If out_ready=1 that cycle, the entry is consumed and not written; count stays 0.
  - If out_ready=0, the entry is written as a normal push.
  - Empty-queue latency is 0 cycles.
- IF_ID_BYPASS_EN undefined: purely registered output path, 1-cycle minimum latency. No combinational path from in_* to out_*.

## Structure
- Shared package if_id_pkg:
  - NOP_INSTR = 32'h0000_0013 (addi x0,x0,0)
  - typedef if_id_entry_t {PC, Instr}, sized by WIDTH via a localparam default of 32
- No sub-module. Pointer/count logic and storage array live in one module. Wrap increment is a local function.

## Test plan
- Reset, then push PC=0x00/Instr=0x00500093 with out_ready=1 -> next cycle out_valid=1, Curr_PC=0x00, Curr_Instr=0x00500093, count=1.
- DEPTH=2, out_ready=0, push PC 0x04, 0x08, 0x0C -> count=2 after two pushes, in_ready=0, the third push is ignored, head stays PC=0x04.
- Full queue, out_ready=1 and in_valid=1 for one cycle -> pop only, count=1, head=0x08, in_ready=1 next cycle.
- DEPTH=3, stream 10 sequential PCs with out_ready toggling every cycle -> output PC order is exactly 0x00..0x24 with no loss or duplication across pointer wrap.
- count=2 plus flush=1, in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, Curr_Instr=0x00000013, Curr_PC=0; the pushed entry is absent.
- IF_ID_BYPASS_EN, empty queue, in_valid=1 with PC=0x40, out_ready=1 -> same cycle out_valid=1, Curr_PC=0x40; next cycle count=0.
